axis_frame_packer: RTL and testbench

- Host-side AXI-Stream master/slave pair for the NN accelerator: packs an 8-bit pixel stream into 32-bit words, drives the accelerator's 32-bit input stream with a frame-end last flag, and receives the accelerator's 4-bit class result stream.
- Sits on the board/FPGA side of the chip pads, facing the chip's stream input and output.
- Also acts as the stimulus/readback engine for silicon bring-up.

---
 rtl/axis_frame_packer.sv | 152 +++++++++++++++
 tb/tb_axis_frame_packer.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_frame_packer.sv
// axis_frame_packer: packs 8-bit pixels little-endian into 32-bit stream words,
// flags the final word of each frame, and collects one 4-bit class result per frame.
//
// state | meaning
// ------+-----------------------------------------------------------------
// FILL  | collecting pixels into the current word, output stream idle
// SEND  | complete word presented on m_axis_*, waiting for the handshake
module axis_frame_packer #(
   parameter int FRAME_PIXELS = 784,
   parameter int CNT_W        = 16
) (
   input  logic             axi_clk,
   input  logic             axi_reset,
   input  logic             pix_valid,
   input  logic [7:0]       pix_data,
   output logic             pix_ready,
   output logic             m_axis_valid,
   output logic [31:0]      m_axis_data,
   output logic             m_axis_last,
   input  logic             m_axis_ready,
   input  logic             s_axis_valid,
   input  logic [3:0]       s_axis_data,
   input  logic             s_axis_last,
   output logic             s_axis_ready,
   output logic             res_valid,
   output logic [3:0]       res_class,
   output logic [CNT_W-1:0] frame_cnt,
   output logic             err
);

   localparam int             PIX_W    = 16;
   localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(FRAME_PIXELS - 1);

   typedef enum logic {
      FILL = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [1:0]       lane;
   logic [PIX_W-1:0] pix_cnt;
   logic [PIX_W-1:0] pix_cnt_next;
   logic [7:0]       outstanding;

   logic pix_fire;
   logic m_fire;
   logic is_final;
   logic word_done;
   logic res_beat;
   logic res_end;
   logic frame_sent;
   logic err_set;

   assign is_final     = (pix_cnt == LAST_PIX);
   assign word_done    = (lane == 2'd3) || is_final;
   assign pix_cnt_next = is_final ? '0 : pix_cnt + PIX_W'(1);
   assign pix_fire     = pix_valid && pix_ready;
   assign m_fire       = m_axis_valid && m_axis_ready;
   assign frame_sent   = m_fire && m_axis_last;
   assign s_axis_ready = !axi_reset;
   assign res_beat     = s_axis_valid && s_axis_ready;
   assign res_end      = res_beat && s_axis_last;

   // A frame send and a result in the same cycle cancel, so neither limit can trip.
   assign err_set = (res_beat && !s_axis_last)
                 || (frame_sent && !res_end && (outstanding == 8'hFF))
                 || (res_end && !frame_sent && (outstanding == 8'h00));

   // State register.
   always_ff @(posedge axi_clk) begin
      if (axi_reset) state <= FILL;
      else           state <= state_next;
   end

   // Next state and stream handshake outputs; a pending word blocks pixels until it moves.
   always_comb begin
      state_next   = state;
      pix_ready    = 1'b0;
      m_axis_valid = 1'b0;
      if (!axi_reset) begin
         case (state)
            FILL: begin
               pix_ready = 1'b1;
               if (pix_valid && word_done) state_next = SEND;
            end
            SEND: begin
               m_axis_valid = 1'b1;
               pix_ready    = m_axis_ready;
               if (m_axis_ready) state_next = (pix_valid && is_final) ? SEND : FILL;
            end
            default: state_next = FILL;
         endcase
      end
   end

   // Word assembly: lanes fill low to high; a handshake starts a zero-cleared word.
   always_ff @(posedge axi_clk) begin
      if (axi_reset) begin
         m_axis_data <= '0;
         m_axis_last <= 1'b0;
         lane        <= 2'd0;
         pix_cnt     <= '0;
      end else if (state == FILL) begin
         if (pix_fire) begin
            m_axis_data[{lane, 3'b000} +: 8] <= pix_data;
            pix_cnt <= pix_cnt_next;
            if (word_done) begin
               lane        <= 2'd0;
               m_axis_last <= is_final;
            end else begin
               lane <= lane + 2'd1;
            end
         end
      end else if (m_fire) begin
         if (pix_fire) begin
            m_axis_data <= {24'h000000, pix_data};
            pix_cnt     <= pix_cnt_next;
            lane        <= is_final ? 2'd0 : 2'd1;
            m_axis_last <= is_final;
         end else begin
            m_axis_data <= '0;
            lane        <= 2'd0;
            m_axis_last <= 1'b0;
         end
      end
   end

   // Result capture, frames-in-flight bookkeeping and sticky error.
   always_ff @(posedge axi_clk) begin
      if (axi_reset) begin
         res_valid   <= 1'b0;
         res_class   <= 4'h0;
         frame_cnt   <= '0;
         outstanding <= 8'h00;
         err         <= 1'b0;
      end else begin
         res_valid <= res_end;
         if (res_end) begin
            res_class <= s_axis_data;
            frame_cnt <= frame_cnt + CNT_W'(1);
         end
         if (frame_sent && !res_end) begin
            if (outstanding != 8'hFF) outstanding <= outstanding + 8'd1;
         end else if (res_end && !frame_sent) begin
            if (outstanding != 8'h00) outstanding <= outstanding - 8'd1;
         end
         if (err_set) err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_axis_frame_packer.sv
// Bench for axis_frame_packer with a 6-pixel frame (two words, the second half-padded).
module tb_axis_frame_packer;

   localparam int FP = 6;

   logic        axi_clk      = 1'b0;
   logic        axi_reset    = 1'b1;
   logic        pix_valid    = 1'b0;
   logic [7:0]  pix_data     = 8'h00;
   logic        pix_ready;
   logic        m_axis_valid;
   logic [31:0] m_axis_data;
   logic        m_axis_last;
   logic        m_axis_ready = 1'b0;
   logic        s_axis_valid = 1'b0;
   logic [3:0]  s_axis_data  = 4'h0;
   logic        s_axis_last  = 1'b0;
   logic        s_axis_ready;
   logic        res_valid;
   logic [3:0]  res_class;
   logic [15:0] frame_cnt;
   logic        err;

   int n_checks = 0;
   int n_fail   = 0;

   axis_frame_packer #(.FRAME_PIXELS(FP), .CNT_W(16)) dut (
      .axi_clk      (axi_clk),
      .axi_reset    (axi_reset),
      .pix_valid    (pix_valid),
      .pix_data     (pix_data),
      .pix_ready    (pix_ready),
      .m_axis_valid (m_axis_valid),
      .m_axis_data  (m_axis_data),
      .m_axis_last  (m_axis_last),
      .m_axis_ready (m_axis_ready),
      .s_axis_valid (s_axis_valid),
      .s_axis_data  (s_axis_data),
      .s_axis_last  (s_axis_last),
      .s_axis_ready (s_axis_ready),
      .res_valid    (res_valid),
      .res_class    (res_class),
      .frame_cnt    (frame_cnt),
      .err          (err)
   );

   always #5 axi_clk = ~axi_clk;

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1, "timeout");
   end

   typedef struct {
      logic        pv;
      logic [7:0]  pd;
      logic        mr;
      logic        sv;
      logic [3:0]  sd;
      logic        sl;
      logic        e_pr;
      logic        e_mv;
      logic [31:0] e_md;
      logic        e_ml;
      logic        e_rv;
      logic [3:0]  e_rc;
      logic [15:0] e_fc;
      logic        e_err;
   } vec_t;

   localparam int NV = 17;
   vec_t tbl [NV];

   function automatic vec_t mk(input int pv, input int pd, input int mr, input int sv,
                               input int sd, input int sl, input int e_pr, input int e_mv,
                               input logic [31:0] e_md, input int e_ml, input int e_rv,
                               input int e_rc, input int e_fc, input int e_err);
      vec_t v;
      v.pv = 1'(pv);  v.pd = 8'(pd);  v.mr = 1'(mr);
      v.sv = 1'(sv);  v.sd = 4'(sd);  v.sl = 1'(sl);
      v.e_pr = 1'(e_pr);  v.e_mv = 1'(e_mv);  v.e_md = e_md;  v.e_ml = 1'(e_ml);
      v.e_rv = 1'(e_rv);  v.e_rc = 4'(e_rc);  v.e_fc = 16'(e_fc);  v.e_err = 1'(e_err);
      return v;
   endfunction

   task automatic chk1(input string nm, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Inputs change on the falling edge; outputs are sampled 1 time unit later.
   task automatic drive(input int pv, input int pd, input int mr, input int sv,
                        input int sd, input int sl);
      @(negedge axi_clk);
      pix_valid    = 1'(pv);
      pix_data     = 8'(pd);
      m_axis_ready = 1'(mr);
      s_axis_valid = 1'(sv);
      s_axis_data  = 4'(sd);
      s_axis_last  = 1'(sl);
      #1;
   endtask

   // One reset cycle with busy inputs, which must all be ignored.
   task automatic do_reset();
      @(negedge axi_clk);
      axi_reset    = 1'b1;
      pix_valid    = 1'b1;
      pix_data     = 8'hFF;
      m_axis_ready = 1'b1;
      s_axis_valid = 1'b1;
      s_axis_data  = 4'hF;
      s_axis_last  = 1'b1;
      #1;
      chk1("rst_pix_ready", pix_ready, 1'b0);
      chk1("rst_s_ready", s_axis_ready, 1'b0);
      @(negedge axi_clk);
      axi_reset    = 1'b0;
      pix_valid    = 1'b0;
      m_axis_ready = 1'b0;
      s_axis_valid = 1'b0;
      s_axis_last  = 1'b0;
      #1;
      chk1("rst_m_valid", m_axis_valid, 1'b0);
      chk32("rst_m_data", m_axis_data, 32'h0);
      chk1("rst_m_last", m_axis_last, 1'b0);
      chk1("rst_res_valid", res_valid, 1'b0);
      chk32("rst_res_class", 32'(res_class), 32'h0);
      chk32("rst_frame_cnt", 32'(frame_cnt), 32'h0);
      chk1("rst_err", err, 1'b0);
      chk1("rst_pix_ready_after", pix_ready, 1'b1);
      chk1("rst_s_ready_after", s_axis_ready, 1'b1);
   endtask

   // Reference model: expected words are built from frame position; at most one waits.
   logic [32:0] pend_q[$];
   logic [31:0] cur_word;
   int          pos;
   int          m_out;
   logic        m_err;
   logic        m_rv;
   logic [3:0]  m_rc;
   logic [15:0] m_fc;

   task automatic model_reset();
      pend_q.delete();
      cur_word = 32'h0;
      pos      = 0;
      m_out    = 0;
      m_err    = 1'b0;
      m_rv     = 1'b0;
      m_rc     = 4'h0;
      m_fc     = 16'h0;
   endtask

   task automatic rand_cycle(input bit beats_on, input int pv_pct, input int mr_pct);
      int          pv, pd, mr, sv, sd, sl;
      logic        e_pr, e_mv, inc, dec;
      logic [32:0] w;
      pv = int'($urandom_range(99) < pv_pct);
      pd = int'($urandom_range(255));
      mr = int'($urandom_range(99) < mr_pct);
      sv = int'(beats_on && (m_out > 0) && ($urandom_range(5) == 0));
      sd = int'($urandom_range(15));
      sl = 1;
      drive(pv, pd, mr, sv, sd, sl);
      e_mv = (pend_q.size() != 0);
      e_pr = !e_mv || (mr != 0);
      chk1("rnd_pix_ready", pix_ready, e_pr);
      chk1("rnd_m_valid", m_axis_valid, e_mv);
      if (e_mv) begin
         chk32("rnd_m_data", m_axis_data, pend_q[0][31:0]);
         chk1("rnd_m_last", m_axis_last, pend_q[0][32]);
      end
      chk1("rnd_res_valid", res_valid, m_rv);
      chk32("rnd_res_class", 32'(res_class), 32'(m_rc));
      chk32("rnd_frame_cnt", 32'(frame_cnt), 32'(m_fc));
      chk1("rnd_err", err, m_err);
      chk1("rnd_s_ready", s_axis_ready, 1'b1);

      inc = 1'b0;
      if (e_mv && (mr != 0)) begin
         w   = pend_q.pop_front();
         inc = w[32];
      end
      if ((pv != 0) && e_pr) begin
         cur_word[(pos % 4) * 8 +: 8] = 8'(pd);
         pos++;
         if ((pos % 4 == 0) || (pos == FP)) begin
            pend_q.push_back({pos == FP, cur_word});
            cur_word = 32'h0;
            if (pos == FP) pos = 0;
         end
      end
      dec  = (sv != 0) && (sl != 0);
      m_rv = dec;
      if (dec) begin
         m_rc = 4'(sd);
         m_fc++;
      end
      if ((sv != 0) && (sl == 0)) m_err = 1'b1;
      if (inc && !dec) begin
         if (m_out == 255) m_err = 1'b1;
         else              m_out++;
      end else if (dec && !inc) begin
         if (m_out == 0) m_err = 1'b1;
         else            m_out--;
      end
   endtask

   initial begin
      //         pv  pd  mr sv sd sl  pr mv  md            ml rv rc fc err
      tbl[0]  = mk(1, 'hA0, 1, 0, 0, 0, 1, 0, 32'h0,        0, 0, 0, 0, 0);
      tbl[1]  = mk(1, 'hA1, 1, 0, 0, 0, 1, 0, 32'h0,        0, 0, 0, 0, 0);
      tbl[2]  = mk(1, 'hA2, 1, 0, 0, 0, 1, 0, 32'h0,        0, 0, 0, 0, 0);
      tbl[3]  = mk(1, 'hA3, 1, 0, 0, 0, 1, 0, 32'h0,        0, 0, 0, 0, 0);
      tbl[4]  = mk(1, 'hA4, 1, 0, 0, 0, 1, 1, 32'hA3A2A1A0, 0, 0, 0, 0, 0);
      tbl[5]  = mk(1, 'hA5, 1, 0, 0, 0, 1, 0, 32'h0,        0, 0, 0, 0, 0);
      tbl[6]  = mk(1, 'hB0, 0, 0, 0, 0, 0, 1, 32'h0000A5A4, 1, 0, 0, 0, 0);
      tbl[7]  = mk(1, 'hB0, 1, 0, 0, 0, 1, 1, 32'h0000A5A4, 1, 0, 0, 0, 0);
      tbl[8]  = mk(0, 0,    1, 1, 7, 1, 1, 0, 32'h0,        0, 0, 0, 0, 0);
      tbl[9]  = mk(0, 0,    1, 0, 0, 0, 1, 0, 32'h0,        0, 1, 7, 1, 0);
      tbl[10] = mk(1, 'hB1, 1, 0, 0, 0, 1, 0, 32'h0,        0, 0, 7, 1, 0);
      tbl[11] = mk(1, 'hB2, 1, 0, 0, 0, 1, 0, 32'h0,        0, 0, 7, 1, 0);
      tbl[12] = mk(1, 'hB3, 1, 0, 0, 0, 1, 0, 32'h0,        0, 0, 7, 1, 0);
      tbl[13] = mk(0, 0,    1, 0, 0, 0, 1, 1, 32'hB3B2B1B0, 0, 0, 7, 1, 0);
      tbl[14] = mk(0, 0,    1, 1, 3, 1, 1, 0, 32'h0,        0, 0, 7, 1, 0);
      tbl[15] = mk(0, 0,    1, 0, 0, 0, 1, 0, 32'h0,        0, 1, 3, 2, 1);
      tbl[16] = mk(0, 0,    1, 0, 0, 0, 1, 0, 32'h0,        0, 0, 3, 2, 1);

      do_reset();
      for (int i = 0; i < NV; i++) begin
         drive(int'(tbl[i].pv), int'(tbl[i].pd), int'(tbl[i].mr),
               int'(tbl[i].sv), int'(tbl[i].sd), int'(tbl[i].sl));
         chk1($sformatf("vec%0d_pix_ready", i), pix_ready, tbl[i].e_pr);
         chk1($sformatf("vec%0d_m_valid", i), m_axis_valid, tbl[i].e_mv);
         if (tbl[i].e_mv) begin
            chk32($sformatf("vec%0d_m_data", i), m_axis_data, tbl[i].e_md);
            chk1($sformatf("vec%0d_m_last", i), m_axis_last, tbl[i].e_ml);
         end
         chk1($sformatf("vec%0d_res_valid", i), res_valid, tbl[i].e_rv);
         chk32($sformatf("vec%0d_res_class", i), 32'(res_class), 32'(tbl[i].e_rc));
         chk32($sformatf("vec%0d_frame_cnt", i), 32'(frame_cnt), 32'(tbl[i].e_fc));
         chk1($sformatf("vec%0d_err", i), err, tbl[i].e_err);
      end

      // Backpressure held for 5 cycles on a pending word.
      do_reset();
      for (int k = 0; k < 4; k++) drive(1, 'hC0 + k, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         drive(1, 'hD0, 0, 0, 0, 0);
         chk1("bp_m_valid", m_axis_valid, 1'b1);
         chk32("bp_m_data", m_axis_data, 32'hC3C2C1C0);
         chk1("bp_m_last", m_axis_last, 1'b0);
         chk1("bp_pix_ready", pix_ready, 1'b0);
      end
      drive(1, 'hD0, 1, 0, 0, 0);
      chk1("bp_release_valid", m_axis_valid, 1'b1);
      chk1("bp_release_ready", pix_ready, 1'b1);
      drive(1, 'hD1, 1, 0, 0, 0);
      chk1("bp_fill_valid", m_axis_valid, 1'b0);
      drive(0, 0, 1, 0, 0, 0);
      chk1("bp_tail_valid", m_axis_valid, 1'b1);
      chk32("bp_tail_data", m_axis_data, 32'h0000D1D0);
      chk1("bp_tail_last", m_axis_last, 1'b1);

      // Result beat without last is a sticky error and captures nothing.
      do_reset();
      drive(0, 0, 0, 1, 5, 0);
      drive(0, 0, 0, 0, 0, 0);
      chk1("nolast_err", err, 1'b1);
      chk1("nolast_res_valid", res_valid, 1'b0);
      chk32("nolast_frame_cnt", 32'(frame_cnt), 32'h0);
      chk32("nolast_res_class", 32'(res_class), 32'h0);
      for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0);
      chk1("nolast_err_sticky", err, 1'b1);

      // Frame-end send and result in the same cycle cancel out.
      do_reset();
      for (int k = 0; k < 6; k++) drive(1, 'hF0 + k, 1, 0, 0, 0);
      drive(0, 0, 1, 1, 9, 1);
      chk1("cancel_m_valid", m_axis_valid, 1'b1);
      chk1("cancel_m_last", m_axis_last, 1'b1);
      drive(0, 0, 1, 0, 0, 0);
      chk1("cancel_err", err, 1'b0);
      chk1("cancel_res_valid", res_valid, 1'b1);
      chk32("cancel_res_class", 32'(res_class), 32'h9);
      chk32("cancel_frame_cnt", 32'(frame_cnt), 32'h1);
      drive(0, 0, 1, 1, 2, 1);
      drive(0, 0, 1, 0, 0, 0);
      chk1("unsolicited_err", err, 1'b1);
      chk32("unsolicited_frame_cnt", 32'(frame_cnt), 32'h2);

      // Reset mid-word and during a pending send.
      do_reset();
      drive(0, 0, 0, 1, 4, 1);
      for (int k = 0; k < 3; k++) drive(1, 'hE0 + k, 1, 0, 0, 0);
      chk32("mid_frame_cnt", 32'(frame_cnt), 32'h1);
      do_reset();
      for (int k = 0; k < 4; k++) drive(1, 'hE0 + k, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0);
      chk1("mid_pending_valid", m_axis_valid, 1'b1);
      do_reset();
      for (int k = 0; k < 4; k++) drive(1, 'h11 + k, 1, 0, 0, 0);
      drive(0, 0, 1, 0, 0, 0);
      chk1("post_rst_valid", m_axis_valid, 1'b1);
      chk32("post_rst_data", m_axis_data, 32'h14131211);
      chk1("post_rst_last", m_axis_last, 1'b0);

      // Random traffic with results only for frames already sent.
      do_reset();
      model_reset();
      repeat (3000) rand_cycle(1'b1, 70, 75);

      // Full-rate frames with no results to saturate the in-flight count, then drain.
      do_reset();
      model_reset();
      repeat (1700) rand_cycle(1'b0, 100, 100);
      chk1("saturation_err", err, 1'b1);
      repeat (300) rand_cycle(1'b1, 90, 80);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
